can_tx_scheduler: RTL and testbench
===================================

Name: can_tx_scheduler

Overview:
- Sequences frames from the can_tx_priority queue into the bit-level CAN transmitter.
- Takes ownership of the queue head by popping it, then holds the frame stable for the whole transmission, so queue preemption cannot corrupt an in-flight frame.
- Handles arbitration-loss retransmission, a bounded error-retry policy, single-shot mode and inter-frame spacing.
- Reports status counters to the register block.

Parameters:
- MAX_RETRY, 3: error retries allowed after the first failed attempt (total attempts = MAX_RETRY+1).
- IFS_CYCLES, 3: idle clock cycles enforced after every attempt ends, before the next fetch.
- CNT_W, 16: width of sent_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  scheduler may start new frames
- single_shot  in  1  no retransmission after an error
- q_empty  in  1  queue empty flag
- q_id  in  11  queue head identifier
- q_dlc  in  4  queue head DLC
- q_data  in  8x8  queue head payload
- q_re  out  1  pop queue head (one-cycle pulse)
- tx_start  out  1  start-of-frame pulse to transmitter
- tx_id  out  11  held frame identifier
- tx_dlc  out  4  held frame DLC
- tx_data  out  8x8  held frame payload
- tx_done  in  1  transmitter: frame sent and acknowledged (pulse)
- tx_arb_lost  in  1  transmitter: arbitration lost (pulse)
- tx_error  in  1  transmitter: bus/ACK error (pulse)
- busy  out  1  scheduler state is not IDLE
- sent_cnt  out  CNT_W  successful transmissions, wraps
- retry_cnt  out  2+  error retries used on the current frame, width $clog2(MAX_RETRY+1)
- abort  out  1  frame dropped after retry exhaustion (one-cycle pulse)
- abort_id  out  11  identifier of the last aborted frame

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0; held frame registers 0.
  - IFS counter 0.
- States: IDLE, FETCH, START, BUSY, IFS. All outputs are registered or Moore.
- IDLE:
  - If enable && !q_empty, go to FETCH. Otherwise stay.
- FETCH (1 cycle):
  - q_re=1.
  - Capture q_id/q_dlc/q_data into the held registers on the same edge.
  - retry_cnt cleared.
  - Go to START.
- START (1 cycle):
  - tx_start=1.
  - tx_id/tx_dlc/tx_data driven from the held registers; they stay stable until the next FETCH.
  - Go to BUSY.
- Latency: queue non-empty in IDLE at cycle N gives q_re at N+1 and tx_start at N+2.
- BUSY: waits for a transmitter event. Same-cycle priority is tx_done > tx_arb_lost > tx_error.
  - tx_done: sent_cnt+1, wrapping at 2^CNT_W. Go to IFS. Frame retired.
  - tx_arb_lost: no retry counting, unlimited retries. Go to IFS, then START again with the same held frame.
  - tx_error with single_shot=1 or retry_cnt==MAX_RETRY: abort=1 for one cycle, abort_id=held id. Go to IFS. Frame retired.
  - tx_error otherwise: retry_cnt+1. Go to IFS, then retry from START.
- IFS:
  - Counts IFS_CYCLES cycles.
  - Then goes to START if a retry is pending, else to IDLE.
  - With IFS_CYCLES=0, passes through IFS in exactly 1 cycle.
- enable:
  - Sampled only in IDLE.
  - Deassertion mid-frame lets the current frame and its retries complete.
  - No new FETCH while enable=0.
- q_re: asserted only in FETCH, which is entered only when q_empty=0, so the queue is never popped when empty.
- A queue write or preemption while the scheduler is not in IDLE does not affect the held frame. A new head is picked up at the next FETCH.
- Transmitter events outside BUSY are ignored.
- Reset mid-operation: the held frame is discarded (not re-queued), tx_start deasserts immediately, and counters clear.

Decomposition:
- Add to can_defs.svh:
  - scheduler state enum (IDLE, FETCH, START, BUSY, IFS);
  - CAN_ID_W=11, CAN_DLC_W=4, CAN_MAX_BYTES=8;
  - a can_frame_t struct (id, dlc, data[8]) used for the held-frame register.
- One sub-module, can_ifs_timer: loadable down-counter with a load/expire handshake, reused later for bus-off recovery timing.

Test Plan:
- Queue head id=300 with dlc=8, enable=1 → q_re one cycle, tx_start next cycle with tx_id=300; tx_done → sent_cnt=1; next q_re no earlier than 3 idle cycles after BUSY exits.
- id=300, two tx_arb_lost then tx_done → three tx_start pulses, all tx_id=300; one q_re total; sent_cnt=1; retry_cnt=0; abort=0.
- id=500, MAX_RETRY=3, four consecutive tx_error → retry_cnt reaches 3; abort pulse with abort_id=500 on the fourth error; next FETCH takes the new head.
- single_shot=1, id=700, one tx_error → immediate abort with abort_id=700; no second tx_start for 700.
- Write id=200 into the queue while id=700 is in BUSY → tx_id stays 700 until tx_done; next frame sent is 200.
- enable dropped during BUSY with the queue non-empty → current frame completes, then no q_re. Separately, rst during BUSY → tx_start=0, busy=0, sent_cnt=0 immediately.

Source files
------------

// File: rtl/can_tx_scheduler_pkg.sv
// Shared CAN frame types, widths and scheduler state encoding.
package can_tx_scheduler_pkg;

    localparam int CAN_ID_W      = 11;
    localparam int CAN_DLC_W     = 4;
    localparam int CAN_MAX_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BUSY,
        ST_IFS
    } sched_state_t;

    typedef struct packed {
        logic [CAN_ID_W-1:0]                id;
        logic [CAN_DLC_W-1:0]               dlc;
        logic [CAN_MAX_BYTES-1:0][7:0]      data;
    } can_frame_t;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/can_ifs_timer.sv
// Loadable down-counter: load starts an interval, expire flags its last cycle.
module can_ifs_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    // Terminal count is 1; a zero load expires on the first cycle
    assign expire = (count == '0) || (count == W'(1));

endmodule

// File: rtl/can_tx_scheduler.sv
// Moves frames from the priority queue into the bit-level CAN transmitter,
// owning each frame from pop until it is sent or dropped.
//
//   state | meaning
//   IDLE  | waiting for enable and a non-empty queue
//   FETCH | pop queue head, capture it into the held frame
//   START | start-of-frame pulse to the transmitter
//   BUSY  | waiting for done / arbitration lost / error
//   IFS   | inter-frame spacing, then retry (START) or IDLE
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter  int MAX_RETRY  = 3,
    parameter  int IFS_CYCLES = 3,
    parameter  int CNT_W      = 16,
    localparam int RW         = cnt_width(MAX_RETRY)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          single_shot,
    input  logic                          q_empty,
    input  logic [CAN_ID_W-1:0]           q_id,
    input  logic [CAN_DLC_W-1:0]          q_dlc,
    input  logic [CAN_MAX_BYTES-1:0][7:0] q_data,
    output logic                          q_re,
    output logic                          tx_start,
    output logic [CAN_ID_W-1:0]           tx_id,
    output logic [CAN_DLC_W-1:0]          tx_dlc,
    output logic [CAN_MAX_BYTES-1:0][7:0] tx_data,
    input  logic                          tx_done,
    input  logic                          tx_arb_lost,
    input  logic                          tx_error,
    output logic                          busy,
    output logic [CNT_W-1:0]              sent_cnt,
    output logic [RW-1:0]                 retry_cnt,
    output logic                          abort,
    output logic [CAN_ID_W-1:0]           abort_id
);

    localparam int TW = cnt_width(IFS_CYCLES);

    sched_state_t state;
    can_frame_t   held;
    logic         retry_pending;
    logic         ifs_load;
    logic         ifs_expire;

    // Any transmitter event ends the attempt and starts the spacing interval
    assign ifs_load = (state == ST_BUSY) && (tx_done || tx_arb_lost || tx_error);

    can_ifs_timer #(
        .W (TW)
    ) u_ifs_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ifs_load),
        .load_val (TW'(IFS_CYCLES)),
        .expire   (ifs_expire)
    );

    // Scheduler FSM with registered strobes, held frame and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            held          <= '0;
            retry_pending <= 1'b0;
            q_re          <= 1'b0;
            tx_start      <= 1'b0;
            sent_cnt      <= '0;
            retry_cnt     <= '0;
            abort         <= 1'b0;
            abort_id      <= '0;
        end else begin
            q_re     <= 1'b0;
            tx_start <= 1'b0;
            abort    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && !q_empty) begin
                        state <= ST_FETCH;
                        q_re  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    held.id       <= q_id;
                    held.dlc      <= q_dlc;
                    held.data     <= q_data;
                    retry_cnt     <= '0;
                    retry_pending <= 1'b0;
                    state         <= ST_START;
                    tx_start      <= 1'b1;
                end
                ST_START: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (tx_done) begin
                        sent_cnt      <= sent_cnt + CNT_W'(1);
                        retry_pending <= 1'b0;
                        state         <= ST_IFS;
                    end else if (tx_arb_lost) begin
                        retry_pending <= 1'b1;
                        state         <= ST_IFS;
                    end else if (tx_error) begin
                        if (single_shot || (retry_cnt == RW'(MAX_RETRY))) begin
                            abort         <= 1'b1;
                            abort_id      <= held.id;
                            retry_pending <= 1'b0;
                        end else begin
                            retry_cnt     <= retry_cnt + RW'(1);
                            retry_pending <= 1'b1;
                        end
                        state <= ST_IFS;
                    end
                end
                ST_IFS: begin
                    if (ifs_expire) begin
                        if (retry_pending) begin
                            state    <= ST_START;
                            tx_start <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tx_id   = held.id;
    assign tx_dlc  = held.dlc;
    assign tx_data = held.data;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Randomized bench for can_tx_scheduler with a FIFO queue model, a scripted
// transmitter responder and an attempt-level reference model.
module tb_can_tx_scheduler;
    import can_tx_scheduler_pkg::*;

    localparam int MAX_RETRY  = 3;
    localparam int IFS_CYCLES = 3;
    localparam int CNT_W      = 16;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          enable, single_shot;
    logic                          q_empty;
    logic [CAN_ID_W-1:0]           q_id;
    logic [CAN_DLC_W-1:0]          q_dlc;
    logic [CAN_MAX_BYTES-1:0][7:0] q_data;
    logic                          q_re, tx_start;
    logic [CAN_ID_W-1:0]           tx_id;
    logic [CAN_DLC_W-1:0]          tx_dlc;
    logic [CAN_MAX_BYTES-1:0][7:0] tx_data;
    logic                          tx_done, tx_arb_lost, tx_error;
    logic                          busy;
    logic [CNT_W-1:0]              sent_cnt;
    logic [1:0]                    retry_cnt;
    logic                          abort;
    logic [CAN_ID_W-1:0]           abort_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    can_tx_scheduler #(
        .MAX_RETRY (MAX_RETRY),
        .IFS_CYCLES(IFS_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot),
        .q_empty(q_empty), .q_id(q_id), .q_dlc(q_dlc), .q_data(q_data),
        .q_re(q_re), .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc),
        .tx_data(tx_data), .tx_done(tx_done), .tx_arb_lost(tx_arb_lost),
        .tx_error(tx_error), .busy(busy), .sent_cnt(sent_cnt),
        .retry_cnt(retry_cnt), .abort(abort), .abort_id(abort_id)
    );

    // Queue model: FIFO ring, popped on the edge that ends a q_re cycle
    can_frame_t qmem [0:63];
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr = '0;
    always @(posedge clk) if (q_re) rd_ptr <= rd_ptr + 6'd1;
    assign q_empty = (rd_ptr == wr_ptr);
    assign q_id    = qmem[rd_ptr].id;
    assign q_dlc   = qmem[rd_ptr].dlc;
    assign q_data  = qmem[rd_ptr].data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation logs, sampled mid-cycle
    int             start_ids[$];
    int             start_retry[$];
    int             start_cyc[$];
    logic [3:0]     start_dlc[$];
    logic [63:0]    start_data[$];
    int             pop_cyc[$];
    int             ev_cyc[$];
    int             abort_ids[$];
    int             abort_cycles = 0;
    int             empty_pops   = 0;
    int             id_glitch    = 0;
    logic [10:0]    lock_id      = '0;

    always @(negedge clk) begin
        if (q_re) begin
            pop_cyc.push_back(cyc);
            if (q_empty) empty_pops++;
        end
        if (tx_start) begin
            start_ids.push_back(int'(tx_id));
            start_retry.push_back(int'(retry_cnt));
            start_cyc.push_back(cyc);
            start_dlc.push_back(tx_dlc);
            start_data.push_back(tx_data);
            lock_id = tx_id;
        end else if (busy && !q_re && tx_id !== lock_id) begin
            id_glitch++;
        end
        if (tx_done || tx_arb_lost || tx_error) ev_cyc.push_back(cyc);
        if (abort) begin
            abort_cycles++;
            abort_ids.push_back(int'(abort_id));
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        can_frame_t f;
        f.id   = id;
        f.dlc  = dlc;
        f.data = data;
        qmem[wr_ptr] = f;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    // 0 done, 1 arb lost, 2 error, 3 done+error, 4 arb lost+error
    task automatic pulse_event(input int code);
        tx_done     = (code == 0) || (code == 3);
        tx_arb_lost = (code == 1) || (code == 4);
        tx_error    = (code >= 2);
        cycles(1);
        tx_done     = 1'b0;
        tx_arb_lost = 1'b0;
        tx_error    = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for the next tx_start, then answers with the given outcome
    task automatic serve(input int code);
        bit ok;
        wait_start(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL serve_timeout: tx_start seen=0 want=1 (code %0d)", code);
        end else begin
            cycles(1);
            cycles($urandom_range(0, 3));
            pulse_event(code);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; single_shot = 1'b0;
        tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
        cycles(3);
        total++; if (q_re !== 1'b0)     begin bad++; $display("FAIL rst_q_re: got %b want 0", q_re); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (sent_cnt !== '0)   begin bad++; $display("FAIL rst_sent_cnt: got %0d want 0", sent_cnt); end
        total++; if (retry_cnt !== '0)  begin bad++; $display("FAIL rst_retry_cnt: got %0d want 0", retry_cnt); end
        total++; if (abort !== 1'b0 || abort_id !== '0) begin bad++; $display("FAIL rst_abort: got %b/%0d want 0/0", abort, abort_id); end
        total++; if ({tx_id, tx_dlc, tx_data} !== '0) begin bad++; $display("FAIL rst_held: got %h want 0", {tx_id, tx_dlc, tx_data}); end
        rst = 1'b0;
        cycles(2);
        enable = 1'b1;
    endtask

    task automatic test_basic();
        int p0, s0, e0, c_push;
        logic [15:0] sent0;
        logic [63:0] d;
        logic [10:0] id2;
        p0 = pop_cyc.size(); s0 = start_ids.size(); e0 = ev_cyc.size(); sent0 = sent_cnt;
        d = rnd64(); id2 = 11'($urandom_range(0, 2047));
        c_push = cyc;
        push_frame(11'd300, 4'd8, d);
        push_frame(id2, 4'($urandom_range(0, 8)), rnd64());
        serve(0);
        serve(0);
        cycles(IFS_CYCLES + 3);
        total++; if (pop_cyc.size() - p0 != 2) begin bad++; $display("FAIL basic_pops: got %0d want 2", pop_cyc.size() - p0); end
        total++; if (pop_cyc[p0] != c_push + 1) begin bad++; $display("FAIL basic_q_re_latency: got %0d want %0d", pop_cyc[p0], c_push + 1); end
        total++; if (start_cyc[s0] != c_push + 2) begin bad++; $display("FAIL basic_start_latency: got %0d want %0d", start_cyc[s0], c_push + 2); end
        total++; if (start_ids[s0] != 300) begin bad++; $display("FAIL basic_tx_id: got %0d want 300", start_ids[s0]); end
        total++; if (start_dlc[s0] !== 4'd8 || start_data[s0] !== d) begin bad++; $display("FAIL basic_payload: got %0d/%h want 8/%h", start_dlc[s0], start_data[s0], d); end
        total++; if (pop_cyc[p0+1] - ev_cyc[e0] != IFS_CYCLES + 2) begin bad++; $display("FAIL basic_ifs_gap: got %0d want %0d", pop_cyc[p0+1] - ev_cyc[e0], IFS_CYCLES + 2); end
        total++; if (start_ids[s0+1] != int'(id2)) begin bad++; $display("FAIL basic_second_id: got %0d want %0d", start_ids[s0+1], id2); end
        total++; if (sent_cnt !== sent0 + 16'd2) begin bad++; $display("FAIL basic_sent_cnt: got %0d want %0d", sent_cnt, sent0 + 16'd2); end
    endtask

    task automatic test_arb_lost();
        int p0, s0, e0, a0;
        logic [15:0] sent0;
        p0 = pop_cyc.size(); s0 = start_ids.size(); e0 = ev_cyc.size(); a0 = abort_ids.size(); sent0 = sent_cnt;
        push_frame(11'd300, 4'd8, rnd64());
        serve(1); serve(1); serve(0);
        cycles(IFS_CYCLES + 3);
        total++; if (start_ids.size() - s0 != 3) begin bad++; $display("FAIL arb_starts: got %0d want 3", start_ids.size() - s0); end
        for (int i = 0; i < 3; i++) begin
            total++; if (start_ids[s0+i] != 300) begin bad++; $display("FAIL arb_tx_id[%0d]: got %0d want 300", i, start_ids[s0+i]); end
        end
        total++; if (start_cyc[s0+1] - ev_cyc[e0] != IFS_CYCLES + 1) begin bad++; $display("FAIL arb_retry_gap: got %0d want %0d", start_cyc[s0+1] - ev_cyc[e0], IFS_CYCLES + 1); end
        total++; if (pop_cyc.size() - p0 != 1) begin bad++; $display("FAIL arb_pops: got %0d want 1", pop_cyc.size() - p0); end
        total++; if (sent_cnt !== sent0 + 16'd1) begin bad++; $display("FAIL arb_sent_cnt: got %0d want %0d", sent_cnt, sent0 + 16'd1); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("FAIL arb_retry_cnt: got %0d want 0", retry_cnt); end
        total++; if (abort_ids.size() != a0) begin bad++; $display("FAIL arb_abort: got %0d want 0", abort_ids.size() - a0); end
    endtask

    task automatic test_error_retry();
        int s0, a0, ac0;
        logic [15:0] sent0;
        logic [10:0] nid;
        s0 = start_ids.size(); a0 = abort_ids.size(); ac0 = abort_cycles; sent0 = sent_cnt;
        nid = 11'($urandom_range(501, 2047));
        push_frame(11'd500, 4'($urandom_range(0, 8)), rnd64());
        push_frame(nid, 4'($urandom_range(0, 8)), rnd64());
        for (int k = 0; k <= MAX_RETRY; k++) serve(2);
        serve(0);
        cycles(IFS_CYCLES + 3);
        total++; if (start_ids.size() - s0 != MAX_RETRY + 2) begin bad++; $display("FAIL err_starts: got %0d want %0d", start_ids.size() - s0, MAX_RETRY + 2); end
        for (int k = 0; k <= MAX_RETRY; k++) begin
            total++; if (start_retry[s0+k] != k || start_ids[s0+k] != 500) begin bad++; $display("FAIL err_attempt[%0d]: got id %0d retry %0d want id 500 retry %0d", k, start_ids[s0+k], start_retry[s0+k], k); end
        end
        total++; if (abort_ids.size() - a0 != 1 || abort_ids[a0] != 500) begin bad++; $display("FAIL err_abort_id: got n=%0d id=%0d want n=1 id=500", abort_ids.size() - a0, abort_ids[a0]); end
        total++; if (abort_cycles - ac0 != 1) begin bad++; $display("FAIL err_abort_width: got %0d want 1", abort_cycles - ac0); end
        total++; if (start_ids[s0+MAX_RETRY+1] != int'(nid)) begin bad++; $display("FAIL err_next_head: got %0d want %0d", start_ids[s0+MAX_RETRY+1], nid); end
        total++; if (sent_cnt !== sent0 + 16'd1 || retry_cnt !== 2'd0) begin bad++; $display("FAIL err_counters: got sent %0d retry %0d want %0d 0", sent_cnt, retry_cnt, sent0 + 16'd1); end
    endtask

    task automatic test_single_shot();
        int s0, a0;
        s0 = start_ids.size(); a0 = abort_ids.size();
        single_shot = 1'b1;
        push_frame(11'd700, 4'd2, rnd64());
        push_frame(11'd701, 4'd3, rnd64());
        serve(2); serve(0);
        cycles(IFS_CYCLES + 3);
        single_shot = 1'b0;
        total++; if (start_ids.size() - s0 != 2 || start_ids[s0] != 700 || start_ids[s0+1] != 701) begin bad++; $display("FAIL ss_starts: got n=%0d %0d,%0d want 2 700,701", start_ids.size() - s0, start_ids[s0], start_ids[s0+1]); end
        total++; if (abort_ids.size() - a0 != 1 || abort_ids[a0] != 700) begin bad++; $display("FAIL ss_abort_id: got n=%0d id=%0d want 1 700", abort_ids.size() - a0, abort_ids[a0]); end
    endtask

    task automatic test_preempt();
        int s0, g0;
        bit ok;
        s0 = start_ids.size(); g0 = id_glitch;
        push_frame(11'd700, 4'd8, rnd64());
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL pre_start_timeout: got 0 want 1"); end
        push_frame(11'd200, 4'd1, rnd64());
        cycles(4);
        total++; if (tx_id !== 11'd700) begin bad++; $display("FAIL pre_held_id: got %0d want 700", tx_id); end
        pulse_event(0);
        serve(0);
        cycles(IFS_CYCLES + 3);
        total++; if (start_ids[s0] != 700 || start_ids[s0+1] != 200) begin bad++; $display("FAIL pre_order: got %0d,%0d want 700,200", start_ids[s0], start_ids[s0+1]); end
        total++; if (id_glitch != g0) begin bad++; $display("FAIL pre_tx_id_stable: got %0d changes want 0", id_glitch - g0); end
    endtask

    task automatic test_enable_drop();
        int p0, s0;
        logic [15:0] sent0;
        logic [10:0] b;
        bit ok;
        p0 = pop_cyc.size(); s0 = start_ids.size(); sent0 = sent_cnt;
        b = 11'($urandom_range(0, 2047));
        push_frame(11'($urandom_range(0, 2047)), 4'd4, rnd64());
        push_frame(b, 4'd5, rnd64());
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL en_start_timeout: got 0 want 1"); end
        enable = 1'b0;
        cycles(1);
        pulse_event(0);
        cycles(30);
        total++; if (pop_cyc.size() - p0 != 1) begin bad++; $display("FAIL en_no_fetch: got %0d pops want 1", pop_cyc.size() - p0); end
        total++; if (sent_cnt !== sent0 + 16'd1 || busy !== 1'b0) begin bad++; $display("FAIL en_complete: got sent %0d busy %b want %0d 0", sent_cnt, busy, sent0 + 16'd1); end
        enable = 1'b1;
        serve(0);
        cycles(IFS_CYCLES + 3);
        total++; if (start_ids[s0+1] != int'(b) || pop_cyc.size() - p0 != 2) begin bad++; $display("FAIL en_resume: got id %0d pops %0d want %0d 2", start_ids[s0+1], pop_cyc.size() - p0, b); end
    endtask

    task automatic test_ignore_idle();
        int s0, a0;
        logic [15:0] sent0;
        s0 = start_ids.size(); a0 = abort_ids.size(); sent0 = sent_cnt;
        pulse_event(0);
        pulse_event(2);
        pulse_event(1);
        cycles(IFS_CYCLES + 3);
        total++; if (sent_cnt !== sent0 || abort_ids.size() != a0) begin bad++; $display("FAIL idle_events: got sent %0d aborts %0d want %0d 0", sent_cnt, abort_ids.size() - a0, sent0); end
        total++; if (busy !== 1'b0 || start_ids.size() != s0) begin bad++; $display("FAIL idle_state: got busy %b starts %0d want 0 0", busy, start_ids.size() - s0); end
    endtask

    task automatic test_random();
        int plan[$];
        int exp_ids[$];
        int exp_retry[$];
        int exp_aborts[$];
        int s0, a0, exp_sent, id, errs, att, r, code;
        bit fin;
        logic [15:0] sent0;
        for (int rep = 0; rep < 2; rep++) begin
            plan.delete(); exp_ids.delete(); exp_retry.delete(); exp_aborts.delete();
            s0 = start_ids.size(); a0 = abort_ids.size(); sent0 = sent_cnt; exp_sent = 0;
            single_shot = (rep == 1);
            for (int f = 0; f < 12; f++) begin
                id = $urandom_range(0, 2047);
                push_frame(11'(id), 4'($urandom_range(0, 8)), rnd64());
                errs = 0; att = 0; fin = 1'b0;
                while (!fin) begin
                    r = $urandom_range(0, 99);
                    code = (r < 40) ? 0 : (r < 60) ? 1 : (r < 90) ? 2 : (r < 95) ? 3 : 4;
                    if (att >= 8) code = 0;
                    plan.push_back(code);
                    exp_ids.push_back(id);
                    exp_retry.push_back(errs);
                    att++;
                    if (code == 0 || code == 3) begin
                        exp_sent++;
                        fin = 1'b1;
                    end else if (code == 2) begin
                        errs++;
                        if (single_shot || errs > MAX_RETRY) begin
                            exp_aborts.push_back(id);
                            fin = 1'b1;
                        end
                    end
                end
            end
            foreach (plan[i]) serve(plan[i]);
            cycles(IFS_CYCLES + 3);
            total++; if (start_ids.size() - s0 != plan.size()) begin bad++; $display("FAIL rnd_starts[%0d]: got %0d want %0d", rep, start_ids.size() - s0, plan.size()); end
            foreach (exp_ids[i]) begin
                total++;
                if (start_ids[s0+i] != exp_ids[i] || start_retry[s0+i] != exp_retry[i]) begin
                    bad++;
                    $display("FAIL rnd_attempt[%0d.%0d]: got id %0d retry %0d want id %0d retry %0d", rep, i, start_ids[s0+i], start_retry[s0+i], exp_ids[i], exp_retry[i]);
                end
            end
            total++; if (abort_ids.size() - a0 != exp_aborts.size()) begin bad++; $display("FAIL rnd_abort_count[%0d]: got %0d want %0d", rep, abort_ids.size() - a0, exp_aborts.size()); end
            foreach (exp_aborts[i]) begin
                total++; if (abort_ids[a0+i] != exp_aborts[i]) begin bad++; $display("FAIL rnd_abort_id[%0d.%0d]: got %0d want %0d", rep, i, abort_ids[a0+i], exp_aborts[i]); end
            end
            total++; if (sent_cnt !== sent0 + 16'(exp_sent)) begin bad++; $display("FAIL rnd_sent_cnt[%0d]: got %0d want %0d", rep, sent_cnt, sent0 + 16'(exp_sent)); end
        end
        single_shot = 1'b0;
        total++; if (empty_pops != 0) begin bad++; $display("FAIL pop_when_empty: got %0d want 0", empty_pops); end
    endtask

    task automatic test_reset_mid();
        int s0;
        bit ok;
        push_frame(11'($urandom_range(0, 2047)), 4'd6, rnd64());
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_start_timeout: got 0 want 1"); end
        rst = 1'b1;
        #1;
        total++; if (tx_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got tx_start %b busy %b want 0 0", tx_start, busy); end
        total++; if (sent_cnt !== '0 || retry_cnt !== '0 || tx_id !== '0) begin bad++; $display("FAIL rmid_clear: got sent %0d retry %0d id %0d want 0 0 0", sent_cnt, retry_cnt, tx_id); end
        cycles(2);
        rst = 1'b0;
        s0 = start_ids.size();
        cycles(10);
        total++; if (start_ids.size() != s0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_discard: got starts %0d busy %b want 0 0", start_ids.size() - s0, busy); end
    endtask

    initial begin
        wr_ptr = '0;
        for (int i = 0; i < 64; i++) qmem[i] = '0;
        test_reset();
        test_basic();
        test_arb_lost();
        test_error_retry();
        test_single_shot();
        test_preempt();
        test_enable_drop();
        test_ignore_idle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
